spi_flash_stream_reader: RTL and testbench

//  Parametrised successor to the flash SPI handler: reads N bytes from an SST25-style SPI flash and streams

---
 rtl/spi_flash_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_spi_flash_stream_reader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_stream_reader.sv
// SST25-style SPI flash reader: issues READ/FAST READ and streams the returned bytes
// over a valid/ready byte interface, stalling SCK when the consumer applies backpressure.
module spi_flash_stream_reader #(
    parameter int CLK_DIV     = 2,
    parameter int ADDR_WIDTH  = 17,
    parameter int NUM_WIDTH   = 12,
    parameter int CS_HIGH_CYC = 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req,
    input  logic                  i_fast_read,
    input  logic [23:0]           i_read_addr,
    input  logic [NUM_WIDTH-1:0]  i_read_num,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_command_error,
    output logic [7:0]            o_byte_data,
    output logic [ADDR_WIDTH-1:0] o_byte_addr,
    output logic                  o_byte_last,
    output logic                  o_byte_valid,
    input  logic                  i_byte_ready,
    output logic                  o_spi_sck,
    output logic                  o_spi_cs_n,
    output logic                  o_spi_si,
    input  logic                  i_spi_so
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DESEL_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
    localparam logic [NUM_WIDTH-1:0]  NUM_ONE  = {{(NUM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_WAIT_OUT, ST_DESEL
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic                  sck;
    logic [2:0]            bit_cnt;
    logic [1:0]            hdr_cnt;
    logic [31:0]           tx_sr;
    logic [7:0]            rx_sr;
    logic [NUM_WIDTH-1:0]  byte_cnt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  fast;
    logic [DESEL_W-1:0]    desel_cnt;
    logic                  err;

    logic active, rise_en, tick, rise, fall, byte_end, out_free;
    logic req_ok, desel_end, take, accept, reject, load_direct, load_pending;

    // SCK only rises while header bits or outstanding data bits remain; a falling
    // half-period is always allowed to finish so SCK parks low.
    always_comb begin
        active    = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DUMMY) ||
                    (state == ST_DATA) || (state == ST_WAIT_OUT);
        rise_en   = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DUMMY) ||
                    ((state == ST_DATA) && (byte_cnt != '0));
        tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
        rise      = rise_en && !sck && tick;
        fall      = active && sck && tick;
        byte_end  = rise && (bit_cnt == 3'd7);
        out_free  = !o_byte_valid || i_byte_ready;
        req_ok    = (i_read_num != '0) && ((i_read_addr >> ADDR_WIDTH) == 24'd0);
        desel_end = (state == ST_DESEL) && (desel_cnt == DESEL_W'(CS_HIGH_CYC - 1));
        take      = i_req && !o_busy;
        accept    = take && req_ok;
        reject    = take && !req_ok;
        load_direct  = (state == ST_DATA) && byte_end && out_free;
        load_pending = (state == ST_WAIT_OUT) && out_free;
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (accept) state_next = ST_CMD;
            ST_CMD:      if (byte_end) state_next = ST_ADDR;
            ST_ADDR:     if (byte_end && (hdr_cnt == 2'd2)) state_next = fast ? ST_DUMMY : ST_DATA;
            ST_DUMMY:    if (byte_end) state_next = ST_DATA;
            ST_DATA: begin
                if (byte_end && !out_free)           state_next = ST_WAIT_OUT;
                else if ((byte_cnt == '0) && !sck)   state_next = ST_DESEL;
            end
            ST_WAIT_OUT: if (out_free) state_next = ST_DATA;
            ST_DESEL:    if (desel_end) state_next = accept ? ST_CMD : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_spi_cs_n = !active;
        o_done     = desel_end;
        o_busy     = (state != ST_IDLE) && !desel_end;
    end

    assign o_spi_sck       = sck;
    assign o_spi_si        = tx_sr[31];
    assign o_command_error = err;

    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            div_cnt      <= '0;
            sck          <= 1'b0;
            bit_cnt      <= 3'd0;
            hdr_cnt      <= 2'd0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            byte_cnt     <= '0;
            cur_addr     <= '0;
            fast         <= 1'b0;
            desel_cnt    <= '0;
            err          <= 1'b0;
            o_byte_data  <= '0;
            o_byte_addr  <= '0;
            o_byte_last  <= 1'b0;
            o_byte_valid <= 1'b0;
        end else begin
            err <= reject;

            if (!active || (!sck && !rise_en) || tick) div_cnt <= '0;
            else                                       div_cnt <= div_cnt + DIV_W'(1);

            if (rise)      sck <= 1'b1;
            else if (fall) sck <= 1'b0;

            if (accept) begin
                tx_sr    <= {(i_fast_read ? 8'h0B : 8'h03), i_read_addr};
                byte_cnt <= i_read_num;
                cur_addr <= i_read_addr[ADDR_WIDTH-1:0];
                fast     <= i_fast_read;
                bit_cnt  <= 3'd0;
                hdr_cnt  <= 2'd0;
            end else begin
                if (fall) tx_sr <= {tx_sr[30:0], 1'b0};
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if ((state == ST_ADDR) && (bit_cnt == 3'd7)) hdr_cnt <= hdr_cnt + 2'd1;
                    if (state == ST_DATA) rx_sr <= {rx_sr[6:0], i_spi_so};
                end
                if ((state == ST_DATA) && byte_end) byte_cnt <= byte_cnt - NUM_ONE;
            end

            if (state == ST_DESEL) desel_cnt <= desel_end ? '0 : desel_cnt + DESEL_W'(1);
            else                   desel_cnt <= '0;

            // A stalled byte waits in rx_sr; by then byte_cnt has already been decremented.
            if (load_direct || load_pending) begin
                o_byte_data  <= load_pending ? rx_sr : {rx_sr[6:0], i_spi_so};
                o_byte_last  <= load_pending ? (byte_cnt == '0) : (byte_cnt == NUM_ONE);
                o_byte_addr  <= cur_addr;
                o_byte_valid <= 1'b1;
                cur_addr     <= cur_addr + ADDR_ONE;
            end else if (o_byte_valid && i_byte_ready) begin
                o_byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Bench for spi_flash_stream_reader: a behavioural SPI flash with random contents feeds
// the DUT and each scenario compares the streamed bytes against the memory image.
module tb_spi_flash_stream_reader;

    localparam int AW       = 17;
    localparam int NW       = 12;
    localparam int MEM_SIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          fast_read = 1'b0;
    logic [23:0]   read_addr = '0;
    logic [NW-1:0] read_num = '0;
    logic          busy, done, command_error;
    logic [7:0]    byte_data;
    logic [AW-1:0] byte_addr;
    logic          byte_last, byte_valid;
    logic          byte_ready = 1'b1;
    logic          spi_sck, spi_cs_n, spi_si;
    logic          spi_so = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_flash_stream_reader #(
        .CLK_DIV(2), .ADDR_WIDTH(AW), .NUM_WIDTH(NW), .CS_HIGH_CYC(4)
    ) dut (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_fast_read(fast_read),
        .i_read_addr(read_addr), .i_read_num(read_num), .o_busy(busy), .o_done(done),
        .o_command_error(command_error), .o_byte_data(byte_data), .o_byte_addr(byte_addr),
        .o_byte_last(byte_last), .o_byte_valid(byte_valid), .i_byte_ready(byte_ready),
        .o_spi_sck(spi_sck), .o_spi_cs_n(spi_cs_n), .o_spi_si(spi_si), .i_spi_so(spi_so)
    );

    // Flash model: header bits shift in on SCK rise, data bits shift out on SCK fall.
    logic [7:0]  mem [0:MEM_SIZE-1];
    int          cs_falls = 0;
    int          sck_rises = 0;
    int          cur_tx = 0;
    int          fl_bits = 0;
    logic [31:0] fl_hdr = '0;

    always @(negedge spi_cs_n) cs_falls++;

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            if (cur_tx != cs_falls) begin
                cur_tx  = cs_falls;
                fl_bits = 0;
                fl_hdr  = '0;
            end
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], spi_si};
            fl_bits++;
            sck_rises++;
        end
    end

    always @(negedge spi_sck) begin
        int hdr, idx, a;
        if (!spi_cs_n) begin
            hdr = (fl_hdr[31:24] == 8'h0B) ? 40 : 32;
            if (fl_bits >= hdr) begin
                idx = fl_bits - hdr;
                a = (int'(fl_hdr[23:0]) + idx / 8) % MEM_SIZE;
                spi_so = mem[a][7 - (idx % 8)];
            end else begin
                spi_so = 1'b0;
            end
        end
    end

    // Consumer: records every valid&ready handshake; readiness set by ready_ctl.
    logic [7:0]    got_data[$];
    logic [AW-1:0] got_addr[$];
    logic          got_last[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int ready_ctl = 0;

    always @(negedge clk) begin
        if (rst_n && byte_valid && byte_ready) begin
            got_data.push_back(byte_data);
            got_addr.push_back(byte_addr);
            got_last.push_back(byte_last);
        end
        if (done) done_cnt++;
        if (command_error) err_cnt++;
    end

    always @(posedge clk) begin
        #1;
        case (ready_ctl)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ($urandom_range(0, 3) != 0);
            default: byte_ready = 1'b0;
        endcase
    end

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic start_read(input logic [23:0] addr, input logic [NW-1:0] num, input bit fast);
        @(posedge clk); #1;
        req = 1'b1; read_addr = addr; read_num = num; fast_read = fast;
        @(posedge clk); #1;
        req = 1'b0; read_addr = 24'($urandom); read_num = NW'($urandom); fast_read = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_cs_n, spi_sck, spi_si} !== 3'b100) begin
            failures++; $display("FAIL reset_spi cs/sck/si=%b expected 100", {spi_cs_n, spi_sck, spi_si});
        end
        checks++;
        if ({busy, done, command_error, byte_valid, byte_last} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got %b expected 00000", {busy, done, command_error, byte_valid, byte_last});
        end
        checks++;
        if (byte_data !== 8'h00 || byte_addr !== '0) begin
            failures++; $display("FAIL reset_data data=%h addr=%h expected 0", byte_data, byte_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream_read(input logic [23:0] addr, input int num, input bit fast,
                                    input int rmode, input bit poke);
        logic [7:0]    exp_q[$];
        logic [AW-1:0] exp_a;
        int  base, done_base, err_base, cs_base, rise_base, n;
        bit  ok;
        base = got_data.size(); done_base = done_cnt; err_base = err_cnt;
        cs_base = cs_falls; rise_base = sck_rises;
        ready_ctl = rmode;
        start_read(addr, NW'(num), fast);
        checks++;
        if (spi_cs_n !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL accept cs_n=%b busy=%b expected 0 1", spi_cs_n, busy);
        end
        ok = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (poke && cyc == 20) begin req = 1'b1; read_num = '0; end
            if (poke && cyc == 21) req = 1'b0;
            if (done_cnt > done_base && got_data.size() - base >= num && !byte_valid) begin
                ok = 1'b1; break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL read_timeout addr=%h num=%0d got %0d bytes", addr, num, got_data.size() - base); end
        for (int i = 0; i < num; i++) exp_q.push_back(mem[(int'(addr) + i) % MEM_SIZE]);
        n = got_data.size() - base;
        checks++;
        if (n != num) begin failures++; $display("FAIL byte_count got %0d expected %0d", n, num); end
        for (int i = 0; i < n && i < num; i++) begin
            exp_a = AW'((int'(addr) + i) % MEM_SIZE);
            checks++;
            if (got_data[base+i] !== exp_q[i] || got_addr[base+i] !== exp_a || got_last[base+i] !== (i == num - 1)) begin
                failures++;
                $display("FAIL byte[%0d] data=%h addr=%h last=%b expected %h %h %b", i,
                         got_data[base+i], got_addr[base+i], got_last[base+i], exp_q[i], exp_a, (i == num - 1));
            end
        end
        checks++;
        if (fl_hdr !== {(fast ? 8'h0B : 8'h03), addr}) begin
            failures++; $display("FAIL header got %h expected %h", fl_hdr, {(fast ? 8'h0B : 8'h03), addr});
        end
        checks++;
        if (sck_rises - rise_base != (fast ? 40 : 32) + 8 * num) begin
            failures++; $display("FAIL sck_count got %0d expected %0d", sck_rises - rise_base, (fast ? 40 : 32) + 8 * num);
        end
        checks++;
        if (cs_falls - cs_base != 1 || done_cnt - done_base != 1 || err_cnt != err_base) begin
            failures++; $display("FAIL framing cs_falls=%0d done=%0d errors=%0d expected 1 1 0",
                                 cs_falls - cs_base, done_cnt - done_base, err_cnt - err_base);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin
            failures++; $display("FAIL end_idle busy=%b cs_n=%b sck=%b expected 0 1 0", busy, spi_cs_n, spi_sck);
        end
    endtask

    task automatic test_backpressure();
        int  base, rise_snap, n;
        logic [7:0] held;
        bit  ok, hold_ok;
        base = got_data.size();
        ready_ctl = 0;
        start_read(24'h000100, 16, 1'b0);
        ok = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (got_data.size() - base >= 3) begin ok = 1'b1; break; end
        end
        ready_ctl = 2;
        repeat (80) @(negedge clk);
        rise_snap = sck_rises; held = byte_data; hold_ok = byte_valid;
        repeat (40) begin
            @(negedge clk);
            if (!byte_valid || byte_data !== held || spi_sck !== 1'b0) hold_ok = 1'b0;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_first_bytes got %0d expected 3", got_data.size() - base); end
        checks++;
        if (sck_rises != rise_snap) begin failures++; $display("FAIL bp_sck_stall rises=%0d expected 0", sck_rises - rise_snap); end
        checks++;
        if (!hold_ok) begin failures++; $display("FAIL bp_hold valid/data/sck not held during stall, expected held"); end
        ready_ctl = 0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (got_data.size() - base >= 16 && !busy && !byte_valid) begin ok = 1'b1; break; end
        end
        n = got_data.size() - base;
        checks++;
        if (!ok || n != 16) begin failures++; $display("FAIL bp_count got %0d expected 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            checks++;
            if (got_data[base+i] !== mem[256 + i] || got_addr[base+i] !== AW'(256 + i) || got_last[base+i] !== (i == 15)) begin
                failures++; $display("FAIL bp_byte[%0d] data=%h addr=%h expected %h %h", i,
                                     got_data[base+i], got_addr[base+i], mem[256 + i], AW'(256 + i));
            end
        end
    endtask

    task automatic test_errors();
        int  err_base, cs_base;
        bit  quiet;
        err_base = err_cnt; cs_base = cs_falls; quiet = 1'b1;
        start_read(24'h000000, 0, 1'b0);
        checks++;
        if (command_error !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL err_num0 error=%b busy=%b expected 1 0", command_error, busy);
        end
        repeat (5) begin @(negedge clk); if (busy || !spi_cs_n) quiet = 1'b0; end
        start_read(24'h020000, 4, 1'b0);
        checks++;
        if (command_error !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL err_addr error=%b busy=%b expected 1 0", command_error, busy);
        end
        repeat (20) begin @(negedge clk); if (busy || !spi_cs_n) quiet = 1'b0; end
        checks++;
        if (err_cnt - err_base != 2) begin failures++; $display("FAIL err_pulses got %0d expected 2", err_cnt - err_base); end
        checks++;
        if (cs_falls != cs_base || !quiet) begin
            failures++; $display("FAIL err_quiet cs_falls=%0d quiet=%b expected 0 1", cs_falls - cs_base, quiet);
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  ok;
        base = got_data.size();
        ready_ctl = 0;
        start_read(24'h000040, 32, 1'b0);
        ok = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (got_data.size() - base >= 5) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (!ok || spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || byte_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid reached=%b cs_n=%b sck=%b valid=%b busy=%b expected 1 1 0 0 0",
                                 ok, spi_cs_n, spi_sck, byte_valid, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_stream_read(24'h000010, 4, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            test_stream_read(24'($urandom_range(0, MEM_SIZE - 1)), $urandom_range(1, 40),
                             1'($urandom_range(0, 1)), 1, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        test_reset();
        test_stream_read(24'h000005, 16, 1'b0, 0, 1'b0);
        test_stream_read(24'h000000, 24, 1'b1, 0, 1'b0);
        test_stream_read(24'h01FFFC, 16, 1'b0, 0, 1'b0);
        test_stream_read(24'h000200, 20, 1'b1, 1, 1'b1);
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
